// File: rtl/xor_sched_pkg.sv
// xor_sched_pkg: shared state encodings and width helpers for shared-cell schedulers
package xor_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  function automatic int ptr_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int w);
    return w > 1 ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/exor_gate.sv
// exor_gate: single two-input XOR cell built from four NAND stages
module exor_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  logic n1, n2, n3;
  assign n1 = ~(a & b);
  assign n2 = ~(a & n1);
  assign n3 = ~(b & n1);
  assign y  = ~(n2 & n3);
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr, wrapping
module rr_arbiter
  import xor_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int PW = ptr_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PW-1:0]    idx_o
);
  logic found;
  int j;
  // scan N_REQ positions starting at ptr and keep the first hit
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(ptr_i) + i) % N_REQ;
      if (!found && req_i[j]) begin
        found = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o = PW'(j);
      end
    end
  end
endmodule

// File: rtl/xor_share_scheduler.sv
// xor_share_scheduler: streams one granted requester's operands bit-serially through a single XOR cell
module xor_share_scheduler
  import xor_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_flat,
  input  logic [N_REQ*WIDTH-1:0] b_flat,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       result
);
  localparam int PW = ptr_w(N_REQ);
  localparam int CW = cnt_w(WIDTH);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_sh_q, res_sh_d, result_q, result_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, win_gnt;
  logic [PW-1:0] idx_q, idx_d, ptr_q, ptr_d, win_idx;
  logic [WIDTH-1:0] a_arr [N_REQ];
  logic [WIDTH-1:0] b_arr [N_REQ];
  logic x_bit;
  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign a_arr[g] = a_flat[g*WIDTH +: WIDTH];
    assign b_arr[g] = b_flat[g*WIDTH +: WIDTH];
  end
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i(req),
    .ptr_i(ptr_q),
    .gnt_o(win_gnt),
    .idx_o(win_idx)
  );
  exor_gate u_xor (
    .a(a_sh_q[0]),
    .b(b_sh_q[0]),
    .y(x_bit)
  );
  // next-state: capture winner in IDLE, shift one bit per cycle, publish and rotate in DONE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    result_d = result_q;
    gnt_d    = gnt_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    unique case (state_q)
      IDLE: if (|req) begin
        state_d = SHIFT;
        gnt_d   = win_gnt;
        idx_d   = win_idx;
        a_sh_d  = a_arr[win_idx];
        b_sh_d  = b_arr[win_idx];
        cnt_d   = '0;
      end
      SHIFT: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = {x_bit, res_sh_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        state_d  = cnt_q == CW'(WIDTH-1) ? DONE : SHIFT;
      end
      DONE: begin
        result_d = res_sh_q;
        gnt_d    = '0;
        ptr_d    = idx_q == PW'(N_REQ-1) ? '0 : idx_q + PW'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset discards any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      gnt_q    <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      result_q <= result_d;
      gnt_q    <= gnt_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
    end
  end
  assign gnt    = gnt_q;
  assign busy   = state_q != IDLE;
  assign done   = state_q == DONE ? gnt_q : '0;
  assign result = result_q;
endmodule

// File: tb/tb_xor_share_scheduler.sv
// tb_xor_share_scheduler: directed checks of arbitration, bit-serial XOR, latency and reset abort
module tb_xor_share_scheduler;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req;
  logic [N*W-1:0] a_flat, b_flat;
  logic [N-1:0] gnt, done;
  logic busy;
  logic [W-1:0] result;
  int checks = 0;
  int errors = 0;
  xor_share_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .a_flat(a_flat),
    .b_flat(b_flat),
    .gnt(gnt),
    .busy(busy),
    .done(done),
    .result(result)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic set_slot(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_flat[i*W +: W] = a;
    b_flat[i*W +: W] = b;
  endtask
  task automatic run_op(input string tag, input int idx, input logic [W-1:0] exp, input bit chg, input bit drop);
    tick;
    chk({tag, "_gnt"}, 32'(gnt), 32'(1 << idx));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    for (int k = 1; k <= W-1; k++) begin
      tick;
      chk({tag, "_early_done"}, 32'(done), 32'd0);
      if (k == 3 && chg) a_flat[idx*W +: W] = ~a_flat[idx*W +: W];
      if (k == 3 && drop) req = '0;
    end
    tick;
    chk({tag, "_done"}, 32'(done), 32'(1 << idx));
    chk({tag, "_gnt_hold"}, 32'(gnt), 32'(1 << idx));
    tick;
    chk({tag, "_result"}, 32'(result), 32'(exp));
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    chk({tag, "_gnt_clr"}, 32'(gnt), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask
  initial begin
    rst = 1'b1;
    req = '0;
    a_flat = 'x;
    b_flat = 'x;
    tick;
    tick;
    rst = 1'b0;
    tick;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    set_slot(0, 8'hA5, 8'h3C);
    req = 4'b0001;
    run_op("single", 0, 8'h99, 1'b0, 1'b0);
    req = '0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    set_slot(0, 8'h12, 8'h34);
    set_slot(1, 8'hF0, 8'h0F);
    set_slot(2, 8'h55, 8'h5A);
    set_slot(3, 8'h81, 8'h18);
    req = 4'b1111;
    run_op("cont0", 0, 8'h26, 1'b0, 1'b0);
    run_op("cont1", 1, 8'hFF, 1'b0, 1'b0);
    run_op("cont2", 2, 8'h0F, 1'b0, 1'b0);
    run_op("cont3", 3, 8'h99, 1'b0, 1'b0);
    run_op("cont4", 0, 8'h26, 1'b0, 1'b0);
    req = 4'b0100;
    run_op("wrap_pre", 2, 8'h0F, 1'b0, 1'b0);
    req = 4'b1001;
    run_op("wrap3", 3, 8'h99, 1'b0, 1'b0);
    run_op("wrap0", 0, 8'h26, 1'b0, 1'b0);
    req = '0;
    set_slot(1, 8'hC3, 8'h0F);
    req = 4'b0010;
    run_op("opchg", 1, 8'hCC, 1'b1, 1'b0);
    req = '0;
    tick;
    chk("opchg_stay_idle", 32'(busy), 32'd0);
    set_slot(0, 8'hA5, 8'h3C);
    req = 4'b0001;
    tick;
    chk("abort_gnt", 32'(gnt), 32'd1);
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_gnt_clr", 32'(gnt), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    run_op("rereq", 0, 8'h99, 1'b0, 1'b0);
    req = '0;
    set_slot(0, 8'hFF, 8'hFF);
    req = 4'b0001;
    run_op("ones", 0, 8'h00, 1'b0, 1'b0);
    set_slot(0, 8'hFF, 8'h00);
    run_op("drop", 0, 8'hFF, 1'b0, 1'b1);
    tick;
    chk("drop_idle", 32'(busy), 32'd0);
    chk("drop_result_hold", 32'(result), 32'hFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
